// File: rtl/alu_operand_entry.sv
// Button-driven operand/opcode entry for a small ALU: four debounced buttons drive a
// four-state editor that commits an operation with a one-cycle issue pulse.
module alu_operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 12000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN1,
  input  logic       BTN2,
  input  logic       BTN3,
  input  logic       BTN_N,
  output logic [1:0] operand_a,
  output logic [1:0] operand_b,
  output logic [2:0] op_sel,
  output logic       issue,
  output logic [1:0] state
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  // Idle level per button, bit order {BTN_N, BTN3, BTN2, BTN1}.
  localparam logic [3:0] BtnIdle = 4'b1000;

  typedef enum logic [1:0] {
    StEditA  = 2'd0,
    StEditB  = 2'd1,
    StEditOp = 2'd2,
    StRun    = 2'd3
  } state_e;

  logic [3:0]      btn_raw;
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      deb_q, deb_prev_q;
  logic [CntW-1:0] cnt_q [4];
  logic [3:0]      press;

  state_e     state_q, state_d;
  logic [1:0] op_a_q, op_a_d;
  logic [1:0] op_b_q, op_b_d;
  logic [2:0] op_sel_q, op_sel_d;
  logic       issue_q, issue_d;

  assign btn_raw = {BTN_N, BTN3, BTN2, BTN1};

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q    <= BtnIdle;
      sync2_q    <= BtnIdle;
      deb_q      <= BtnIdle;
      deb_prev_q <= BtnIdle;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          cnt_q[i] <= '0;
          deb_q[i] <= ~deb_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // A press is a debounced change that moves away from the idle level.
  assign press = (deb_q ^ deb_prev_q) & (deb_q ^ BtnIdle);

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_sel_d = op_sel_q;
    issue_d  = 1'b0;
    if (press[3]) begin
      state_d  = StEditA;
      op_a_d   = '0;
      op_b_d   = '0;
      op_sel_d = '0;
    end else if (press[1]) begin
      unique case (state_q)
        StEditA:  state_d = StEditB;
        StEditB:  state_d = StEditOp;
        StEditOp: begin
          state_d = StRun;
          issue_d = 1'b1;
        end
        StRun:    state_d = StEditA;
        default:  state_d = StEditA;
      endcase
    end else if (press[0]) begin
      case (state_q)
        StEditA:  op_a_d   = op_a_q + 2'd1;
        StEditB:  op_b_d   = op_b_q + 2'd1;
        StEditOp: op_sel_d = op_sel_q + 3'd1;
        default:  ;
      endcase
    end else if (press[2]) begin
      case (state_q)
        StEditA:  op_a_d   = '0;
        StEditB:  op_b_d   = '0;
        StEditOp: op_sel_d = '0;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StEditA;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sel_q <= '0;
      issue_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_sel_q <= op_sel_d;
      issue_q  <= issue_d;
    end
  end

  assign operand_a = op_a_q;
  assign operand_b = op_b_q;
  assign op_sel    = op_sel_q;
  assign issue     = issue_q;
  assign state     = state_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Self-checking bench: event-level reference model scheduled from the stimulus, compared
// against the DUT every cycle, plus hand-computed literal checkpoints.
module tb_alu_operand_entry;

  localparam int N = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN1 = 1'b0, BTN2 = 1'b0, BTN3 = 1'b0, BTN_N = 1'b1;
  logic [1:0] operand_a, operand_b, state;
  logic [2:0] op_sel;
  logic       issue;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int issue_cnt = 0;
  bit chk_en = 1'b0;

  // Model: fields and the press events expected at a given edge index.
  int         m_state = 0, m_a = 0, m_b = 0, m_op = 0;
  logic       m_issue = 1'b0;
  logic [3:0] sched [int];
  logic [3:0] ev;

  alu_operand_entry #(.DEBOUNCE_CYCLES(N)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BTN1     (BTN1),
    .BTN2     (BTN2),
    .BTN3     (BTN3),
    .BTN_N    (BTN_N),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .op_sel   (op_sel),
    .issue    (issue),
    .state    (state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_issue = 1'b0;
      sched.delete();
    end else begin
      ev = sched.exists(cyc) ? sched[cyc] : 4'b0000;
      m_issue = 1'b0;
      if (ev[3]) begin
        m_state = 0; m_a = 0; m_b = 0; m_op = 0;
      end else if (ev[1]) begin
        if (m_state == 2) m_issue = 1'b1;
        m_state = (m_state + 1) % 4;
      end else if (ev[0]) begin
        if (m_state == 0) m_a = (m_a + 1) % 4;
        else if (m_state == 1) m_b = (m_b + 1) % 4;
        else if (m_state == 2) m_op = (m_op + 1) % 8;
      end else if (ev[2]) begin
        if (m_state == 0) m_a = 0;
        else if (m_state == 1) m_b = 0;
        else if (m_state == 2) m_op = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("state", state, m_state);
      check("operand_a", operand_a, m_a);
      check("operand_b", operand_b, m_b);
      check("op_sel", op_sel, m_op);
      check("issue", issue, m_issue);
      if (issue === 1'b1) issue_cnt++;
    end
  end

  // Mask bits: 0 BTN1, 1 BTN2, 2 BTN3, 3 BTN_N (active meaning).
  task automatic set_btns(input logic [3:0] m);
    BTN1  = m[0];
    BTN2  = m[1];
    BTN3  = m[2];
    BTN_N = ~m[3];
  endtask

  // Called at a negedge: first sample is edge cyc+1, FSM acts at edge cyc+N+3.
  task automatic schedule(input logic [3:0] m);
    int k;
    k = cyc + N + 3;
    if (sched.exists(k)) sched[k] = sched[k] | m;
    else sched[k] = m;
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    if (hold >= N) schedule(m);
    set_btns(m);
    repeat (hold) @(negedge CLK);
    set_btns(4'b0000);
    repeat (N + 4) @(negedge CLK);
  endtask

  task automatic tap(input logic [3:0] m);
    press(m, N + 1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    int i0;
    set_btns(4'b0000);
    RST = 1'b1;
    @(negedge CLK);
    chk_en = 1'b1;
    @(negedge CLK);
    check("rst_state", state, 0);
    check("rst_a", operand_a, 0);
    check("rst_b", operand_b, 0);
    check("rst_op", op_sel, 0);
    check("rst_issue", issue, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Exact latency: held from edge 1, update lands on edge N+3.
    schedule(4'b0001);
    BTN1 = 1'b1;
    repeat (N + 2) @(negedge CLK);
    check("lat_early", operand_a, 0);
    @(negedge CLK);
    check("lat_edge", operand_a, 1);
    repeat (2) @(negedge CLK);
    BTN1 = 1'b0;
    repeat (N + 4) @(negedge CLK);
    press(4'b0001, N - 1);
    check("glitch", operand_a, 1);

    // Full entry A=3, B=1, op=1, then RUN.
    do_reset();
    repeat (3) tap(4'b0001);
    tap(4'b0010);
    tap(4'b0001);
    tap(4'b0010);
    repeat (9) tap(4'b0001);
    i0 = issue_cnt;
    tap(4'b0010);
    check("run_state", state, 3);
    check("run_a", operand_a, 3);
    check("run_b", operand_b, 1);
    check("run_op", op_sel, 1);
    check("run_issue_once", issue_cnt - i0, 1);
    tap(4'b0001);
    tap(4'b0100);
    check("run_hold_a", operand_a, 3);
    check("run_hold_op", op_sel, 1);
    check("run_hold_issue", issue_cnt - i0, 1);
    tap(4'b0010);
    check("wrap_state", state, 0);
    check("keep_b", operand_b, 1);

    // Wrap and clear.
    do_reset();
    repeat (5) tap(4'b0001);
    check("a_wrap", operand_a, 1);
    tap(4'b0100);
    check("a_clear", operand_a, 0);
    tap(4'b0010);
    tap(4'b0010);
    repeat (8) tap(4'b0001);
    check("op_wrap", op_sel, 0);
    check("op_state", state, 2);

    // Priority.
    do_reset();
    repeat (2) tap(4'b0001);
    tap(4'b0011);
    check("pri_state", state, 1);
    check("pri_a", operand_a, 2);
    tap(4'b0010);
    tap(4'b0001);
    i0 = issue_cnt;
    tap(4'b1010);
    check("abort_state", state, 0);
    check("abort_a", operand_a, 0);
    check("abort_op", op_sel, 0);
    check("abort_issue", issue_cnt - i0, 0);

    // Reset in RUN while BTN1 is held.
    tap(4'b0001);
    repeat (3) tap(4'b0010);
    check("pre_rst_run", state, 3);
    schedule(4'b0001);
    BTN1 = 1'b1;
    repeat (N + 6) @(negedge CLK);
    do_reset();
    check("mid_rst_state", state, 0);
    check("mid_rst_a", operand_a, 0);
    schedule(4'b0001);
    repeat (N + 6) @(negedge CLK);
    BTN1 = 1'b0;
    repeat (N + 4) @(negedge CLK);
    check("held_rel_a", operand_a, 1);
    check("held_rel_state", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
